// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Execute-stage helper for the decoder FSM. It runs RV32 loads and stores on a
// 32-bit memory bus that has no byte enables. Sub-word stores therefore read
// the word first, merge the new lanes in, and write the whole word back.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low (unit held idle while 0)
//   start          one-cycle request strobe, accepted only when idle
//   isStore        1 = store, 0 = load (sampled with start)
//   funct3         access width / signedness code (sampled with start)
//   addrIn         effective byte address (sampled with start)
//   storeData      rs2 value for stores (sampled with start)
//   loadData       extended load result, valid with done, held until next start
//   done           one-cycle completion pulse
//   fault          pulses with done for misaligned or illegal accesses
//   busy           high while an accepted access is in progress
//   busAddress     word-aligned bus address
//   busDataOut     bus write data
//   busDataIn      bus read data
//   busWriteEnable 1 during the single write cycle of a store
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] addrIn,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic        done,
    output logic        fault,
    output logic        busy,
    output logic [31:0] busAddress,
    output logic [31:0] busDataOut,
    input  logic [31:0] busDataIn,
    output logic        busWriteEnable
);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE,
        FINISH
    } lsuState;

    lsuState     state;
    logic [2:0]  waitCount;
    logic        opStore;
    logic [2:0]  opFunct3;
    logic [1:0]  opOffset;
    logic [15:0] opData;

    logic        reqLegal;
    logic        reqMisaligned;
    logic        reqFault;
    logic        reqWordStore;

    // Pulls the addressed byte/halfword out of the read word and extends it.
    function automatic logic [31:0] extractLoad(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replaces only the lanes being stored; every other lane keeps the read value.
    function automatic logic [31:0] mergeStore(input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic [31:0] word,
                                               input logic [15:0] data);
        logic [31:0] r;
        r = word;
        if (size == 2'd0) begin
            case (off)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end else if (off[1]) begin
            r[31:16] = data;
        end else begin
            r[15:0] = data;
        end
        return r;
    endfunction

    // Request classification. Loads allow 0,1,2,4,5; stores allow 0,1,2.
    always_comb begin
        reqLegal      = isStore ? (!funct3[2] && funct3[1:0] != 2'b11)
                                : (funct3[1:0] != 2'b11 && !(funct3[2] && funct3[1]));
        reqMisaligned = (funct3[1:0] == 2'd1 && addrIn[0]) ||
                        (funct3[1:0] == 2'd2 && addrIn[1:0] != 2'b00);
        reqFault      = !reqLegal || reqMisaligned;
        reqWordStore  = isStore && funct3[1:0] == 2'd2;
    end

    // Main sequencer. done/fault default low so they only ever pulse for one
    // cycle; bus address/data simply hold when nothing updates them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            waitCount      <= '0;
            opStore        <= 1'b0;
            opFunct3       <= '0;
            opOffset       <= '0;
            opData         <= '0;
            loadData       <= '0;
            done           <= 1'b0;
            fault          <= 1'b0;
            busy           <= 1'b0;
            busAddress     <= '0;
            busDataOut     <= '0;
            busWriteEnable <= 1'b0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (reqFault) begin
                            done     <= 1'b1;
                            fault    <= 1'b1;
                            loadData <= '0;
                        end else begin
                            opStore    <= isStore;
                            opFunct3   <= funct3;
                            opOffset   <= addrIn[1:0];
                            opData     <= storeData[15:0];
                            busAddress <= {addrIn[31:2], 2'b00};
                            busy       <= 1'b1;
                            if (reqWordStore) begin
                                busDataOut     <= storeData;
                                busWriteEnable <= 1'b1;
                                state          <= WRITE;
                            end else begin
                                busWriteEnable <= 1'b0;
                                waitCount      <= 3'(READ_LATENCY - 1);
                                state          <= READ_WAIT;
                            end
                        end
                    end
                end
                READ_WAIT: begin
                    if (waitCount == 3'd0) begin
                        if (opStore) begin
                            busDataOut     <= mergeStore(opFunct3[1:0], opOffset, busDataIn, opData);
                            busWriteEnable <= 1'b1;
                            state          <= WRITE;
                        end else begin
                            loadData <= extractLoad(opFunct3, opOffset, busDataIn);
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        waitCount <= waitCount - 3'd1;
                    end
                end
                WRITE: begin
                    busWriteEnable <= 1'b0;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= FINISH;
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
